// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the pixel-writer state type.
// The scan-out stage imports the same image geometry.
package fb_pkg;

  localparam int IMG_W      = 320;
  localparam int IMG_H      = 240;
  localparam int IMG_PIXELS = IMG_W * IMG_H;
  localparam int SLOT1_BASE = IMG_PIXELS;
  localparam int ADDR_W     = 18;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } fbw_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; head word is visible on o_data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Writes one IMG_W x IMG_H RGB frame from a valid/ready stream into one of two
// frame-memory slots, buffering through a small FIFO to ride out write stalls.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int IMG_W      = fb_pkg::IMG_W,
  parameter int IMG_H      = fb_pkg::IMG_H,
  parameter int ADDR_W     = fb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_slot,
  input  logic              i_px_valid,
  input  logic [23:0]       i_px_data,
  output logic              o_px_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  input  logic              i_wr_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] LP_PIXELS = ADDR_W'(IMG_W * IMG_H);

  fbw_state_t        r_state;
  fbw_state_t        w_state_next;
  logic [ADDR_W-1:0] r_accept_cnt;
  logic [ADDR_W-1:0] r_write_cnt;
  logic [ADDR_W-1:0] r_base;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [23:0]       r_wr_data;

  logic              w_push;
  logic              w_load;
  logic              w_wr_done;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [23:0]       w_fifo_head;
  logic [ADDR_W-1:0] w_next_idx;

  sync_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_px_data),
    .i_pop   (w_load),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign o_px_ready = (r_state == FILL) && !w_fifo_full && (r_accept_cnt < LP_PIXELS);
  assign w_push     = i_px_valid && o_px_ready;
  assign w_wr_done  = r_wr_en && !i_wr_stall;
  assign w_load     = !w_fifo_empty && (!r_wr_en || w_wr_done);
  // Index of the pixel being loaded: one past the write that completes this cycle.
  assign w_next_idx = r_write_cnt + (w_wr_done ? ADDR_W'(1) : '0);

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = {8'h00, r_wr_data};
  assign o_busy    = (r_state == FILL) || (r_state == DRAIN);
  assign o_done    = (r_state == DONE);

  always_comb begin
    w_state_next = r_state;
    o_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_next = FILL;
      end
      FILL: begin
        o_err = i_start;
        if (r_accept_cnt == LP_PIXELS) w_state_next = DRAIN;
      end
      DRAIN: begin
        o_err = i_start;
        if (r_write_cnt == LP_PIXELS) w_state_next = DONE;
      end
      DONE: begin
        o_err        = i_start;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_accept_cnt <= '0;
      r_write_cnt  <= '0;
      r_base       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state <= w_state_next;

      if (r_state == IDLE && i_start) begin
        r_base       <= i_slot ? LP_PIXELS : '0;
        r_accept_cnt <= '0;
        r_write_cnt  <= '0;
      end else begin
        if (w_push)    r_accept_cnt <= r_accept_cnt + ADDR_W'(1);
        if (w_wr_done) r_write_cnt  <= r_write_cnt + ADDR_W'(1);
      end

      // A stalled write keeps the whole output stage frozen.
      if (w_load) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_base + w_next_idx;
        r_wr_data <= w_fifo_head;
      end else if (w_wr_done) begin
        r_wr_en <= 1'b0;
      end
    end
  end

endmodule
